regfile_mp: RTL

Parametrised multi-port integer register file for the NPC core. It adds the following:
- a second write port, so an ALU and a load/multicycle result can retire in the same cycle;
- a configurable number of read ports;
- a per-register busy scoreboard for in-flight producers;
- a sequenced clear (sweep) operation.

It sits between decode (reads, issue) and writeback (writes) and replaces the single-write regfile.

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 119 +++++++++++
 2 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: both write ports, packed read ports, issue and sweep control.
// The master drives requests; the slave (the register file) returns read data, busy and clr_busy.
interface regfile_mp_if #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int RD_PORTS = 2
);
  localparam int AW = $clog2(NREGS);

  logic                     wen0;
  logic [AW-1:0]            waddr0;
  logic [XLEN-1:0]          wdata0;
  logic                     wen1;
  logic [AW-1:0]            waddr1;
  logic [XLEN-1:0]          wdata1;
  logic [RD_PORTS*AW-1:0]   raddr;
  logic [RD_PORTS*XLEN-1:0] rdata;
  logic [RD_PORTS-1:0]      rbusy;
  logic                     issue_en;
  logic [AW-1:0]            issue_rd;
  logic                     clr_req;
  logic                     clr_busy;

  modport master (
    output wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, issue_en, issue_rd, clr_req,
    input  rdata, rbusy, clr_busy
  );

  modport slave (
    input  wen0, waddr0, wdata0, wen1, waddr1, wdata1, raddr, issue_en, issue_rd, clr_req,
    output rdata, rbusy, clr_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write ports, busy scoreboard and a sequenced clear sweep.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter int              RD_PORTS = 2,
  parameter logic [XLEN-1:0] RST_DATA = '0
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int            AW       = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_IDX = '0;
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t                   state_q;
  logic [AW-1:0]            idx_q;
  logic                     clr_busy_q;
  logic [XLEN-1:0]          regs_q [NREGS];
  logic [NREGS-1:0]         busy_q;
  logic [NREGS-1:0]         busy_d;
  logic [RD_PORTS*XLEN-1:0] rdata_c;
  logic [RD_PORTS-1:0]      rbusy_c;

  // Scoreboard next state: writes clear, a same-cycle issue wins over the clear.
  always_comb begin
    busy_d = busy_q;
    if (state_q == ST_SWEEP) begin
      busy_d[idx_q] = 1'b0;
    end else begin
      if (bus.wen0) busy_d[bus.waddr0] = 1'b0;
      else          busy_d = busy_d;
      if (bus.wen1) busy_d[bus.waddr1] = 1'b0;
      else          busy_d = busy_d;
      if (bus.issue_en) busy_d[bus.issue_rd] = 1'b1;
      else              busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Register storage and sweep sequencer; reg 0 is held at zero and never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 0) ? {XLEN{1'b0}} : RST_DATA;
      end
      busy_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= ONE_IDX;
      clr_busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        ST_IDLE: begin
          if (bus.wen0 && (bus.waddr0 != ZERO_IDX)) regs_q[bus.waddr0] <= bus.wdata0;
          // Port 1 is assigned last so it wins a same-address collision.
          if (bus.wen1 && (bus.waddr1 != ZERO_IDX)) regs_q[bus.waddr1] <= bus.wdata1;
          if (bus.clr_req) begin
            state_q    <= ST_SWEEP;
            idx_q      <= ONE_IDX;
            clr_busy_q <= 1'b1;
          end
        end
        ST_SWEEP: begin
          regs_q[idx_q] <= RST_DATA;
          if (idx_q == LAST_IDX) begin
            state_q    <= ST_IDLE;
            idx_q      <= ONE_IDX;
            clr_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + ONE_IDX;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          idx_q      <= ONE_IDX;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Combinational read ports from stored state, optionally forwarding same-cycle writes.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (bus.raddr[k*AW +: AW] == ZERO_IDX) begin
        rdata_c[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rbusy_c[k]              = 1'b0;
      end else begin
        rdata_c[k*XLEN +: XLEN] = regs_q[bus.raddr[k*AW +: AW]];
        rbusy_c[k]              = busy_q[bus.raddr[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if ((state_q == ST_IDLE) && bus.wen1 && (bus.waddr1 == bus.raddr[k*AW +: AW])) begin
          rdata_c[k*XLEN +: XLEN] = bus.wdata1;
          rbusy_c[k]              = 1'b0;
        end else if ((state_q == ST_IDLE) && bus.wen0 && (bus.waddr0 == bus.raddr[k*AW +: AW])) begin
          rdata_c[k*XLEN +: XLEN] = bus.wdata0;
          rbusy_c[k]              = 1'b0;
        end else begin
          rbusy_c[k] = rbusy_c[k];
        end
`endif
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.clr_busy = clr_busy_q;
endmodule
